// File: rtl/regfile_pkg.sv
// Shared definitions for the ARM register file.
// Contents: data/address widths, register count, PC index and reset value,
// and a register-name enum (R0..R15 with SP/LR/PC aliases).
package regfile_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned REG_ADDR_W = 4;

  localparam logic [REG_ADDR_W-1:0] PC_IDX   = 4'hF;
  localparam logic [DATA_W-1:0]     PC_RESET = 32'h0000_0000;

  typedef enum logic [REG_ADDR_W-1:0] {
    R0  = 4'd0,  R1  = 4'd1,  R2  = 4'd2,  R3  = 4'd3,
    R4  = 4'd4,  R5  = 4'd5,  R6  = 4'd6,  R7  = 4'd7,
    R8  = 4'd8,  R9  = 4'd9,  R10 = 4'd10, R11 = 4'd11,
    R12 = 4'd12, R13 = 4'd13, R14 = 4'd14, R15 = 4'd15
  } reg_name_e;

  // Enum labels must have unique values, so the architectural aliases are
  // separate constants of the enum type.
  localparam reg_name_e SP = R13;
  localparam reg_name_e LR = R14;
  localparam reg_name_e PC = R15;

endpackage

// File: rtl/binary_decoder_4to16.sv
// 4-to-16 one-hot decoder with enable. Purely combinational.
// Ports:
//   SEL    - 4-bit register number
//   EN     - enable; when low the output is all zeros
//   ONEHOT - ONEHOT[i] = EN & (SEL == i)
module binary_decoder_4to16
  import regfile_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] SEL,
  input  logic                  EN,
  output logic [NUM_REGS-1:0]   ONEHOT
);

  always_comb begin
    ONEHOT = '0;
    if (EN) begin
      ONEHOT[SEL] = 1'b1;
    end
  end

endmodule

// File: rtl/register_write_bank.sv
// Write side of the ARM register file: 16 x DATA_W registers R0..R15.
// Ports:
//   clk, rst_n     - rising-edge clock, synchronous active-low reset
//   PW, RW, LE     - general write port (data, destination, enable)
//   PC_IN, PC_LE   - dedicated R15 load from fetch
//   Q0..Q15        - current register contents, in parallel
//   WR_ONEHOT      - registered decoded write enables from the last edge
// A general write to R15 takes priority over a simultaneous PC load.
module register_write_bank
  import regfile_pkg::*;
#(
  parameter int unsigned      DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned      NUM_REGS = regfile_pkg::NUM_REGS,
  parameter logic [DATA_W-1:0] PC_RESET = regfile_pkg::PC_RESET
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     PW,
  input  logic [REG_ADDR_W-1:0] RW,
  input  logic                  LE,
  input  logic [DATA_W-1:0]     PC_IN,
  input  logic                  PC_LE,
  output logic [DATA_W-1:0]     Q0,
  output logic [DATA_W-1:0]     Q1,
  output logic [DATA_W-1:0]     Q2,
  output logic [DATA_W-1:0]     Q3,
  output logic [DATA_W-1:0]     Q4,
  output logic [DATA_W-1:0]     Q5,
  output logic [DATA_W-1:0]     Q6,
  output logic [DATA_W-1:0]     Q7,
  output logic [DATA_W-1:0]     Q8,
  output logic [DATA_W-1:0]     Q9,
  output logic [DATA_W-1:0]     Q10,
  output logic [DATA_W-1:0]     Q11,
  output logic [DATA_W-1:0]     Q12,
  output logic [DATA_W-1:0]     Q13,
  output logic [DATA_W-1:0]     Q14,
  output logic [DATA_W-1:0]     Q15,
  output logic [NUM_REGS-1:0]   WR_ONEHOT
);

  logic [NUM_REGS-1:0] onehot;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  binary_decoder_4to16 u_dec (
    .SEL    (RW),
    .EN     (LE),
    .ONEHOT (onehot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
        regs[i] <= '0;
      end
      regs[PC_IDX] <= PC_RESET;
      WR_ONEHOT    <= '0;
    end else begin
      WR_ONEHOT <= onehot;
      for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
        if (onehot[i]) begin
          regs[i] <= PW;
        end
      end
      // Branch / data-processing write to PC overrides the sequential load.
      if (onehot[PC_IDX]) begin
        regs[PC_IDX] <= PW;
      end else if (PC_LE) begin
        regs[PC_IDX] <= PC_IN;
      end
    end
  end

  assign Q0  = regs[0];
  assign Q1  = regs[1];
  assign Q2  = regs[2];
  assign Q3  = regs[3];
  assign Q4  = regs[4];
  assign Q5  = regs[5];
  assign Q6  = regs[6];
  assign Q7  = regs[7];
  assign Q8  = regs[8];
  assign Q9  = regs[9];
  assign Q10 = regs[10];
  assign Q11 = regs[11];
  assign Q12 = regs[12];
  assign Q13 = regs[13];
  assign Q14 = regs[14];
  assign Q15 = regs[15];

endmodule
